// File: rtl/fir4_pkg.sv
// Shared constants and the divide-by-four helper for the FIR output stage.
// ROUND_EN (in the top level) selects round-half-up versus truncation.
package fir4_pkg;

  localparam int W_DEF      = 16;
  localparam int WARMUP_DEF = 5;

  localparam logic [15:0] OVF_MAX = 16'hFFFF;

  // Works on a wide container so any W up to ~60 bits fits without loss;
  // callers cast the result down to W bits.
  function automatic logic [63:0] fir4_avg(input logic [63:0] s, input logic round);
    logic [63:0] t;
    t = s + (round ? 64'd2 : 64'd0);
    return t >> 2;
  endfunction

endpackage

// File: rtl/fir4_out_fifo.sv
// Synchronous FIFO with a first-word-fall-through head register.
// The caller must never push while full unless it pops on the same edge.
module fir4_out_fifo
  import fir4_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_data,
  output logic [W-1:0]             o_data,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [W-1:0]  r_head;
  logic          r_valid;

  logic          w_pop;
  logic [AW-1:0] w_rd_nxt;
  logic [LW-1:0] w_level_nxt;

  // A pop on an empty FIFO is ignored.
  assign w_pop    = i_pop & r_valid;
  assign w_rd_nxt = r_rd_ptr + AW'(1);

  always_comb begin
    w_level_nxt = r_level;
    case ({i_push, w_pop})
      2'b10:   w_level_nxt = r_level + LW'(1);
      2'b01:   w_level_nxt = r_level - LW'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  // The head register mirrors mem[rd_ptr]; when the entry behind the head is
  // the one being written this edge, take it straight from i_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_head   <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= w_rd_nxt;
      r_level <= w_level_nxt;
      r_valid <= (w_level_nxt != '0);
      if (i_push && ((r_level == LW'(0)) || (w_pop && (r_level == LW'(1)))))
        r_head <= i_data;
      else if (w_pop && (r_level > LW'(1)))
        r_head <= r_mem[w_rd_nxt];
    end
  end

  assign o_data  = r_head;
  assign o_valid = r_valid;
  assign o_level = r_level;

endmodule

// File: rtl/fir4_out_stage.sv
// Output stage after the 4-tap FIR adder: warm-up discard, divide-by-four,
// FIFO buffering and drop counting. Define ROUND_EN for round-half-up.
module fir4_out_stage
  import fir4_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int DEPTH  = 8,
  parameter int WARMUP = WARMUP_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [W+1:0]             s_in,
  output logic [W-1:0]             out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              ovf_cnt,
  input  logic                     ovf_clr
);

  localparam int LW  = $clog2(DEPTH) + 1;
  localparam int WCW = $clog2(WARMUP + 1);

`ifdef ROUND_EN
  localparam logic ROUND = 1'b1;
`else
  localparam logic ROUND = 1'b0;
`endif

  logic [WCW-1:0] r_warm_cnt;
  logic [15:0]    r_ovf_cnt;

  logic           w_warm;
  logic [W-1:0]   w_avg;
  logic           w_pop;
  logic           w_full;
  logic           w_push;
  logic           w_drop;

  assign w_warm = (r_warm_cnt == WCW'(WARMUP));
  assign w_avg  = W'(fir4_avg(64'(s_in), ROUND));

  // Valid/ready: a word transfers on every edge where out_valid and
  // out_ready are both high; out_data is stable while out_valid waits.
  assign w_pop  = out_valid & out_ready;
  assign w_full = (level == LW'(DEPTH));
  assign w_push = w_warm & (~w_full | w_pop);
  assign w_drop = w_warm & w_full & ~w_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_warm_cnt <= '0;
    end else if (!w_warm) begin
      r_warm_cnt <= r_warm_cnt + WCW'(1);
    end
  end

  // A clear wins over a drop on the same edge, and that drop is not counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf_cnt <= '0;
    end else if (ovf_clr) begin
      r_ovf_cnt <= '0;
    end else if (w_drop && (r_ovf_cnt != OVF_MAX)) begin
      r_ovf_cnt <= r_ovf_cnt + 16'd1;
    end
  end

  fir4_out_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_avg),
    .o_data  (out_data),
    .o_valid (out_valid),
    .o_level (level)
  );

  assign ovf_cnt = r_ovf_cnt;

endmodule

// File: doc/fir4_out_stage.md
# fir4_out_stage

Downstream consumer of the free-running 4-tap FIR adder output. Takes the (W+2)-bit tap sum every clock, discards pipeline warm-up samples, divides by four with optional rounding to form a W-bit moving average, and buffers results in a small FIFO. The FIFO drains over a valid/ready interface, so a stalling sink never stalls the FIR; overflowed samples are dropped and counted.

## Interface
- W, 16, FIR input sample width; `s_in` is W+2 bits, `out_data` is W bits
- DEPTH, 8, FIFO entries; power of two, 2..64
- WARMUP, 5, samples discarded after reset: 4 tap fills plus 1 output register
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- s_in  input  W+2  FIR tap sum; sampled every clock, no valid qualifier
- out_data  output  W  head-of-FIFO average; first-word-fall-through
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  sink accepts `out_data` when high with `out_valid`
- level  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH
- ovf_cnt  output  16  dropped-sample count; saturates at 16'hFFFF
- ovf_clr  input  1  synchronous pulse; zeroes `ovf_cnt`

## Operation
- Reset values: out_valid=0, out_data=0, level=0, ovf_cnt=0; warm-up counter=0; FIFO pointers=0.
- Warm-up: counter increments on each clock edge while below WARMUP. A sample is pushed only on edges where the counter already equals WARMUP, so the first WARMUP edges after reset release are discarded. The counter holds at WARMUP until the next reset.
- Average: avg = (s_in + 2) >> 2, with the add at W+3 bits. Maximum result is 2^W-1, so no saturation is required. Result is the low W bits.
- Push: `push` = warm. Accepted when `level < DEPTH`, or when `level == DEPTH` and a pop occurs on the same edge.
- Pop: `pop` = out_valid & out_ready.
- Level update: push only → +1; pop only → −1; both → unchanged.
- Full: a push with no pop at `level == DEPTH` is dropped, and `ovf_cnt` increments, saturating at 16'hFFFF.
- Overflow clear: `ovf_clr` has priority over an increment on the same edge; the result is 0, and that drop is not counted.
- Empty: out_valid=0 and out_data holds its last value. A pop with out_valid low is ignored.
- Pointers wrap modulo DEPTH. Full and empty are distinguished by `level`.
- Reset mid-operation: all contents are lost, out_valid falls immediately (asynchronously), and warm-up restarts.

## Timing
- Sample-to-output latency is 1 edge. An `s_in` sampled at edge N while the FIFO is empty appears on out_data/out_valid directly after edge N.
- A pop at edge N presents the next entry directly after edge N, or out_valid=0 if the FIFO is now empty.
- out_valid, out_data, level and ovf_cnt are registered outputs. There are no combinational paths from inputs to outputs.
- After reset release, the first push occurs at edge WARMUP+1.

## Configuration
- ROUND_EN defined: avg = (s_in + 2) >> 2, round half up.
- ROUND_EN undefined: avg = s_in >> 2, truncation. Timing and all other behaviour are identical.

## Structure
- The shared package `fir4_pkg` holds:
  - the width constant W_DEF=16 and WARMUP_DEF=5;
  - the function `fir4_avg(s, round)` that returns the W-bit average;
  - the constant OVF_MAX=16'hFFFF.
- One sub-module, `fir4_out_fifo`:
  - parameterised synchronous FIFO (W, DEPTH) with push/pop, level and FWFT head register;
  - asynchronous active-high reset;
  - the overflow decision lives in the top level, not in the FIFO.
- The top level contains the warm-up counter, the average datapath, push gating and the overflow counter.

## Test plan
- Reset release, s_in=18'd400 constant, out_ready=1 → out_valid first rises after edge 6, out_data=100; no earlier output.
- ROUND_EN: s_in=18'd6 → out_data=2; s_in=18'd5 → 1. Without ROUND_EN: 6 → 1, 5 → 1. Max case: s_in=18'h3FFFC → 16'hFFFF in both builds.
- Overflow: out_ready=0 for 20 post-warm-up edges with DEPTH=8 → level=8 and ovf_cnt=12.
  - Then ovf_clr with out_ready=0 → ovf_cnt=0 on the next edge.
  - Then out_ready=1 drains the entries in push order.
- Full with simultaneous pop: level=8, out_ready=1 for one edge → level stays 8, ovf_cnt unchanged, and the newest sample is stored.
- Mid-stream reset: assert reset with level=5 → out_valid=0 and level=0 without a clock edge. After release, 5 discarded edges occur before the next push.
- Saturation: force 65540 drops → ovf_cnt=16'hFFFF, and it holds there.
